// File: rtl/pipeline_stall_controller_if.sv
// Stall/flush control bundle between the hazard sources and the pipeline registers.
//   Hazard side (driven by master): load_use_hazard, ex_branch_taken, ex_mdu_op,
//     ex_mdu_is_div, mem_req, mem_ready
//   Control side (driven by slave): per-stage *_write / *_flush, pc_write,
//     mdu_start, mdu_busy
interface pipeline_stall_controller_if;
  logic load_use_hazard;
  logic ex_branch_taken;
  logic ex_mdu_op;
  logic ex_mdu_is_div;
  logic mem_req;
  logic mem_ready;

  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_write;
  logic id_ex_flush;
  logic ex_mem_write;
  logic ex_mem_flush;
  logic mem_wb_write;
  logic mem_wb_flush;
  logic mdu_start;
  logic mdu_busy;

  // Stall controller side
  modport slave (
    input  load_use_hazard, ex_branch_taken, ex_mdu_op, ex_mdu_is_div,
           mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, ex_mem_flush, mem_wb_write, mem_wb_flush,
           mdu_start, mdu_busy
  );

  // Pipeline / hazard-detection side
  modport master (
    output load_use_hazard, ex_branch_taken, ex_mdu_op, ex_mdu_is_div,
           mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, ex_mem_flush, mem_wb_write, mem_wb_flush,
           mdu_start, mdu_busy
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Merges load-use, taken-branch, multi-cycle MDU and data-memory wait events
// into per-stage register enables/bubble controls and the MDU start pulse.
// Outputs are Mealy (combinational from state and inputs).
//   clk   : pipeline clock, rising edge
//   reset : asynchronous, active-high; forces all writes 0 and all flushes 1
//   bus   : slave side of pipeline_stall_controller_if
module pipeline_stall_controller #(
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  pipeline_stall_controller_if.slave   bus
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] MDU_WAIT = 2'd2;

  // First cycle is spent in RUN, the last in MDU_WAIT with cnt == 0.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic ex_mem_write, ex_mem_flush, mem_wb_write, mem_wb_flush;
  logic mdu_start, mdu_busy;

  // State and MDU counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and Mealy output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_write = 1'b1;
    mem_wb_flush = 1'b0;
    mdu_start    = 1'b0;
    mdu_busy     = 1'b0;

    if (reset) begin
      // Hold every stage and bubble everything while reset is applied
      state_d      = RUN;
      cnt_d        = '0;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.mem_req && !bus.mem_ready) begin
            // Memory stall freezes everything up to MEM; WB gets a bubble
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
            state_d      = MEM_WAIT;
          end else if (bus.ex_mdu_op) begin
            // Launch the MDU; front end holds, MEM receives bubbles
            mdu_start    = 1'b1;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
            cnt_d        = bus.ex_mdu_is_div ? DIV_LOAD : MUL_LOAD;
            state_d      = MDU_WAIT;
          end else if (bus.ex_branch_taken) begin
            // Redirect: squash the two younger instructions
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
          end else if (bus.load_use_hazard) begin
            // Hold PC and IF/ID one cycle, insert a bubble into EX
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
          end
        end

        MEM_WAIT: begin
          if (!bus.mem_ready) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
          end else begin
            state_d      = RUN;
          end
        end

        MDU_WAIT: begin
          mdu_busy = 1'b1;
          if (cnt_q != '0) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
            cnt_d        = cnt_q - CNT_W'(1);
          end else begin
            // Final MDU cycle: result leaves EX with everything advancing
            state_d      = RUN;
          end
        end

        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_write  = id_ex_write;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_write = ex_mem_write;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.mem_wb_write = mem_wb_write;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.mdu_start    = mdu_start;
  assign bus.mdu_busy     = mdu_busy;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: table of one-cycle
// vectors plus hand-written divide and asynchronous-reset sequences.
module tb_pipeline_stall_controller;

  logic clk;
  logic reset;

  pipeline_stall_controller_if bus ();

  pipeline_stall_controller #(
    .MUL_CYCLES (3),
    .DIV_CYCLES (33),
    .CNT_W      (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input bits: {load_use, branch, mdu_op, is_div, mem_req, mem_ready}
  localparam logic [5:0] I_IDLE = 6'b000000;
  localparam logic [5:0] I_LU   = 6'b100000;
  localparam logic [5:0] I_BR   = 6'b010000;
  localparam logic [5:0] I_MUL  = 6'b001000;
  localparam logic [5:0] I_DIV  = 6'b001100;
  localparam logic [5:0] I_MREQ = 6'b000010;
  localparam logic [5:0] I_MRDY = 6'b000001;

  // Output bits: {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f,
  //               memwb_w, memwb_f, mdu_start, mdu_busy}
  localparam logic [10:0] E_DEF    = 11'b1_1_0_1_0_1_0_1_0_0_0;
  localparam logic [10:0] E_RST    = 11'b0_0_1_0_1_0_1_0_1_0_0;
  localparam logic [10:0] E_MEMFRZ = 11'b0_0_0_0_0_0_0_1_1_0_0;
  localparam logic [10:0] E_MDUST  = 11'b0_0_0_0_0_1_1_1_0_1_0;
  localparam logic [10:0] E_MDUW   = 11'b0_0_0_0_0_1_1_1_0_0_1;
  localparam logic [10:0] E_MDUREL = 11'b1_1_0_1_0_1_0_1_0_0_1;
  localparam logic [10:0] E_BR     = 11'b1_1_1_1_1_1_0_1_0_0_0;
  localparam logic [10:0] E_LU     = 11'b0_0_0_1_1_1_0_1_0_0_0;

  typedef struct {
    string       name;
    logic [5:0]  in;
    logic [10:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [10:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  function automatic logic [10:0] dut_out();
    return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_write,
            bus.id_ex_flush, bus.ex_mem_write, bus.ex_mem_flush,
            bus.mem_wb_write, bus.mem_wb_flush, bus.mdu_start, bus.mdu_busy};
  endfunction

  task automatic check(input string name, input logic [10:0] got,
                       input logic [10:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic drive(input logic [5:0] v);
    {bus.load_use_hazard, bus.ex_branch_taken, bus.ex_mdu_op,
     bus.ex_mdu_is_div, bus.mem_req, bus.mem_ready} = v;
  endtask

  // One cycle: drive after the edge, queue the expectation, compare at negedge
  task automatic step(input string name, input logic [5:0] v,
                      input logic [10:0] exp);
    sb_t e;
    drive(v);
    sb_q.push_back('{name, exp});
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      check(e.name, dut_out(), e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{"idle0",          I_IDLE,                  E_DEF},
      '{"idle1",          I_IDLE,                  E_DEF},
      '{"load_use",       I_LU,                    E_LU},
      '{"load_use_after", I_IDLE,                  E_DEF},
      '{"branch",         I_BR,                    E_BR},
      '{"branch_lu",      I_BR | I_LU,             E_BR},
      '{"idle2",          I_IDLE,                  E_DEF},
      '{"mem_hit",        I_MREQ | I_MRDY,         E_DEF},
      '{"mem_hit_lu",     I_MREQ | I_MRDY | I_LU,  E_LU},
      '{"mem_miss_br",    I_MREQ | I_BR,           E_MEMFRZ},
      '{"memwait1",       I_MREQ | I_BR,           E_MEMFRZ},
      '{"memwait2_other", I_MREQ | I_BR | I_LU | I_MUL, E_MEMFRZ},
      '{"memwait3",       I_MREQ | I_BR,           E_MEMFRZ},
      '{"mem_release",    I_MREQ | I_MRDY | I_BR,  E_DEF},
      '{"branch_deferred",I_BR,                    E_BR},
      '{"mem_over_mdu",   I_MREQ | I_MUL,          E_MEMFRZ},
      '{"mem_release2",   I_MREQ | I_MRDY | I_MUL, E_DEF},
      '{"mul_start",      I_MUL,                   E_MDUST},
      '{"mul_wait",       I_MUL | I_BR | I_LU,     E_MDUW},
      '{"mul_release",    I_MUL,                   E_MDUREL},
      '{"idle3",          I_IDLE,                  E_DEF}
    };

    drive(I_IDLE);
    reset = 1'b1;
    #1;
    check("reset_outputs", dut_out(), E_RST);
    @(posedge clk);
    #1;
    check("reset_held", dut_out(), E_RST);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) step(vecs[i].name, vecs[i].in, vecs[i].exp);

    // Divide: 33 cycles in EX, released on the 33rd
    step("div_start", I_DIV, E_MDUST);
    for (int k = 1; k <= 31; k++) step($sformatf("div_wait%0d", k), I_DIV, E_MDUW);
    step("div_release", I_DIV, E_MDUREL);
    step("div_idle", I_IDLE, E_DEF);

    // Reset mid-divide: cnt is 10 in cycle t+22
    step("div2_start", I_DIV, E_MDUST);
    for (int k = 1; k <= 21; k++) step($sformatf("div2_wait%0d", k), I_DIV, E_MDUW);
    drive(I_DIV);
    #1;
    check("div2_wait22_pre_reset", dut_out(), E_MDUW);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_mid_mdu", dut_out(), E_RST);
    @(posedge clk);
    #1;
    check("reset_mid_mdu_held", dut_out(), E_RST);
    drive(I_IDLE);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step("post_reset_idle0", I_IDLE, E_DEF);
    step("post_reset_idle1", I_IDLE, E_DEF);
    step("post_reset_mul", I_MUL, E_MDUST);
    step("post_reset_mulw", I_MUL, E_MDUW);
    step("post_reset_mulr", I_MUL, E_MDUREL);
    step("post_reset_idle2", I_IDLE, E_DEF);

    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Merges the ID-stage load-use hazard flag, EX-stage taken-branch redirect, multi-cycle mul/div occupancy in EX and data-memory wait states in MEM. Produces per-stage pipeline-register write enables and bubble (flush) controls, plus the MDU start pulse. Sits beside the hazard detection logic and drives every pipeline register and the PC.

Parameters:
MUL_CYCLES, 3, total cycles a multiply occupies EX (must be >= 2)
DIV_CYCLES, 33, total cycles a divide/remainder occupies EX (must be >= 2)
CNT_W, 6, width of the MDU cycle counter (must hold DIV_CYCLES-2)

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
load_use_hazard  in  1  ID instruction depends on a load currently in EX
ex_branch_taken  in  1  EX resolved taken branch or jump; PC redirect valid
ex_mdu_op  in  1  EX holds a mul/div instruction
ex_mdu_is_div  in  1  qualifies ex_mdu_op: 1 = divide/remainder, 0 = multiply
mem_req  in  1  MEM holds a load or store
mem_ready  in  1  data memory completes the MEM access this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID loads a NOP
id_ex_write  out  1  ID/EX register enable
id_ex_flush  out  1  ID/EX loads a bubble (controls zeroed)
ex_mem_write  out  1  EX/MEM register enable
ex_mem_flush  out  1  EX/MEM loads a bubble
mem_wb_write  out  1  MEM/WB register enable
mem_wb_flush  out  1  MEM/WB loads a bubble
mdu_start  out  1  single-cycle start pulse to the MDU
mdu_busy  out  1  high while in MDU_WAIT

Behaviour:
- Registered state: FSM {RUN, MEM_WAIT, MDU_WAIT} and CNT_W-bit counter cnt. Outputs are combinational from state and inputs (Mealy).
- While reset is high: state = RUN, cnt = 0. All *_write outputs are 0, all *_flush outputs are 1, mdu_start = 0, mdu_busy = 0.
- Default (no event): all writes = 1, all flushes = 0, mdu_start = 0.
- RUN evaluates events in priority order, highest first:
  1. mem_req & !mem_ready: pc/if_id/id_ex/ex_mem writes = 0; mem_wb_write = 1 with mem_wb_flush = 1. Next state MEM_WAIT. A branch or load-use hazard in the same cycle is deferred.
  2. ex_mdu_op: mdu_start = 1; pc/if_id/id_ex writes = 0; ex_mem_flush = 1; MEM/WB advances normally. cnt loads N-2, where N = DIV_CYCLES if ex_mdu_is_div, else MUL_CYCLES. Next state MDU_WAIT.
  3. ex_branch_taken: if_id_flush = 1, id_ex_flush = 1, pc_write = 1. Overrides load_use_hazard, because the ID instruction is squashed.
  4. load_use_hazard: pc_write = 0, if_id_write = 0, id_ex_flush = 1. EX, MEM and WB advance.
- MEM_WAIT: same freeze outputs as RUN event 1 while !mem_ready. When mem_ready = 1: default outputs (everything advances), next state RUN. Other inputs are ignored in this state.
- MDU_WAIT: mdu_busy = 1. While cnt != 0: same freeze outputs as RUN event 2 but with mdu_start = 0, and cnt decrements. When cnt == 0: default outputs (the MDU op leaves EX), next state RUN. mem_req is 0 by construction (MEM holds bubbles) and is ignored. branch and load-use inputs are ignored.
- Latency: the MDU instruction occupies EX for exactly N cycles, with no re-trigger on return to RUN. A load-use stall lasts 1 cycle per assertion. The branch penalty is 2 bubbles.
- Asynchronous reset mid-MDU or mid-MEM wait aborts immediately to RUN; no partial-state carry-over.

Test Plan:
- Idle: all inputs 0 after reset deassert -> all writes = 1, all flushes = 0, state RUN, indefinitely.
- Load-use: load_use_hazard = 1 for 1 cycle -> pc_write = 0, if_id_write = 0, id_ex_flush = 1 for that cycle only; next cycle defaults.
- Divide: ex_mdu_op = 1, ex_mdu_is_div = 1 at cycle t -> mdu_start = 1 only at t; PC/IF/ID/ID-EX frozen for t..t+31; ex_mem_flush = 1 for t..t+31; release at t+32 (33 cycles total); mdu_busy = 1 for t+1..t+32. Repeat with multiply -> release at t+2.
- Memory wait: mem_req = 1, mem_ready = 0 for 4 cycles with ex_branch_taken = 1 -> 4 frozen cycles, mem_wb_flush = 1, no IF/ID flush. Then mem_ready = 1 -> advance and return to RUN; the branch flush applies on the next RUN cycle.
- Simultaneous branch + load-use in RUN -> if_id_flush = 1, id_ex_flush = 1, pc_write = 1.
- Reset asserted during MDU_WAIT with cnt = 10 -> outputs go to reset values asynchronously. After release: state RUN, mdu_busy = 0, no spurious mdu_start.
